vco_gate_driver: RTL
====================

# vco_gate_driver

Variable-frequency complementary gate generator for the resonant converter half-bridge. It sits directly downstream of the PI controller and its output clamp. It consumes the clamped control value as a half-period length in clock cycles and produces the high-side/low-side gate signals with programmable dead time. It also emits a once-per-period sync strobe that the control loop uses as its sample instant.

## Interface
- `N_BIT`, 32: width of the control input.
- `DEAD_TIME`, 10: dead-time length in clock cycles, ≥1.
- `MIN_HALF`, 50: minimum accepted half-period in cycles; must be > `DEAD_TIME`.
- `MAX_HALF`, 2000: maximum accepted half-period in cycles.
- `i_CLK` input 1: system clock; single clock domain.
- `i_RST` input 1: reset, asynchronous, active-low.
- `i_EN` input 1: run enable, level-sensitive.
- `i_HALF` input `N_BIT` signed: requested half-period in cycles, from the clamp stage.
- `o_GATE_H` output 1: high-side gate command.
- `o_GATE_L` output 1: low-side gate command.
- `o_SYNC` output 1: one-cycle pulse on the first cycle of every period.
- `o_HALF` output `N_BIT` signed: half-period currently in use (latched value).

## Operation
- States: `IDLE`, `DT_A`, `ON_A`, `DT_B`, `ON_B`. One down-counter `cnt` and one latched half-period `half_q`.
- Reset (async, `i_RST`=0):
  - state=`IDLE`, `cnt`=0, `half_q`=`MIN_HALF`.
  - All outputs 0, except `o_HALF`=`MIN_HALF`.
- `IDLE`:
  - Gates low.
  - If `i_EN`=1, go to `DT_A` on the next edge. This is a period boundary.
- Period boundary, i.e. entry into `DT_A` from `IDLE` or `ON_B`:
  - Latch `half_q` = clamp(`i_HALF`, `MIN_HALF`, `MAX_HALF`).
  - Negative `i_HALF` clamps to `MIN_HALF`.
  - Load `cnt`=`DEAD_TIME`-1.
  - Assert `o_SYNC` for this one cycle.
- `DT_A`:
  - Both gates low for `DEAD_TIME` cycles.
  - Then go to `ON_A` with `cnt`=`half_q`-`DEAD_TIME`-1.
- `ON_A`:
  - `o_GATE_H`=1 for `half_q`-`DEAD_TIME` cycles.
  - Then go to `DT_B` with `cnt`=`DEAD_TIME`-1.
- `DT_B`:
  - Both gates low for `DEAD_TIME` cycles.
  - Then go to `ON_B`.
- `ON_B`:
  - `o_GATE_L`=1 for `half_q`-`DEAD_TIME` cycles.
  - Then return to `DT_A`, which is the next period boundary.
- `i_HALF` changes mid-period are ignored until the next boundary. Frequency updates are glitch-free and always apply to whole periods.
- `i_EN`=0 in any non-`IDLE` state:
  - Next edge goes to `IDLE` and both gates go 0.
  - No pending half-period completes; safe shutdown has priority.
- `i_EN`=0 and the boundary condition occur in the same cycle: `i_EN` wins. Go to `IDLE`, no latch, no `o_SYNC`.
- Invariant: `o_GATE_H` & `o_GATE_L` is never 1. Every high↔low transition passes through ≥`DEAD_TIME` cycles with both gates low.

## Timing
- All outputs are registered and valid in the same cycle as the state they decode. No combinational path from any input to any output.
- Enable latency: `i_EN` sampled high at edge k → `DT_A` and `o_SYNC`=1 during cycle k+1 → `o_GATE_H` rises at edge k+1+`DEAD_TIME`.
- Period is exactly 2·`half_q` cycles:
  - `o_GATE_H` high for `half_q`-`DEAD_TIME` cycles.
  - `o_GATE_L` high for `half_q`-`DEAD_TIME` cycles.
  - `o_SYNC` spacing is exactly 2·`half_q`.
- Disable latency: `i_EN` sampled low at edge k → both gates 0 from edge k+1.
- Reset asserted mid-operation: gates drop immediately (asynchronously). The next run restarts from `IDLE`.
- Width rules:
  - Clamp compare is signed, `N_BIT` wide.
  - `cnt` is `$clog2(MAX_HALF)` bits wide.
  - `half_q`-`DEAD_TIME`-1 cannot underflow, because `MIN_HALF` > `DEAD_TIME`.

## Structure
- The shared include file `resonant_defs.vh` holds the state encodings as `localparam` (3-bit) and the default `DEAD_TIME`/`MIN_HALF`/`MAX_HALF`. The PI and clamp stages use the same defaults.
- One combinational sub-module, `half_clamp`, implements the signed clamp of `i_HALF`. It is parameterised by `N_BIT`, `MIN_HALF` and `MAX_HALF`.
- Top level holds the FSM, the counter and the output registers.

## Test plan
- **Steady run:** `DEAD_TIME`=10, `i_HALF`=100, `i_EN`=1 → `o_SYNC` every 200 cycles. `o_GATE_H` high 90 cycles and `o_GATE_L` high 90 cycles, each preceded by 10 dead cycles.
- **Mid-period update:** change `i_HALF` 100→300 during `ON_A`. The current period stays 200 cycles; the next period is 600 cycles; `o_HALF` updates on the `o_SYNC` cycle.
- **Clamping:**
  - `i_HALF`=20 → `o_HALF`=50, period 100.
  - `i_HALF`=-5 → `o_HALF`=50.
  - `i_HALF`=5000 → `o_HALF`=2000, period 4000.
- **Disable mid `ON_B`:** `i_EN`→0 → both gates 0 next cycle, state `IDLE`. Re-enable → `o_SYNC` one cycle later, then `o_GATE_H` 10 cycles after that.
- **Async reset in `ON_A`:** pulse `i_RST` low between clock edges → `o_GATE_H` drops without a clock edge, `o_HALF`=50. After release with `i_EN`=1, a normal start sequence follows.
- **Overlap check:** random `i_HALF`/`i_EN` traffic for 10^5 cycles → assertion never sees both gates high, and never sees a direct H↔L transition shorter than `DEAD_TIME` dead cycles.

Source files
------------

// File: rtl/vco_gate_driver_pkg.sv
// Shared definitions for the resonant half-bridge gate generator:
// FSM state encoding and the default timing constants also used by the
// PI and clamp stages.
package vco_gate_driver_pkg;

    localparam int DEF_N_BIT     = 32;
    localparam int DEF_DEAD_TIME = 10;
    localparam int DEF_MIN_HALF  = 50;
    localparam int DEF_MAX_HALF  = 2000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DT_A = 3'd1,
        ON_A = 3'd2,
        DT_B = 3'd3,
        ON_B = 3'd4
    } state_t;

endpackage

// File: rtl/half_clamp.sv
// Signed saturation of the requested half-period into [MIN_HALF, MAX_HALF].
// Negative requests land on MIN_HALF because the compare is signed.
module half_clamp
    import vco_gate_driver_pkg::*;
#(
    parameter int N_BIT    = DEF_N_BIT,
    parameter int MIN_HALF = DEF_MIN_HALF,
    parameter int MAX_HALF = DEF_MAX_HALF
) (
    input  logic signed [N_BIT-1:0] half,
    output logic signed [N_BIT-1:0] clamped
);

    localparam logic signed [N_BIT-1:0] MIN_V = N_BIT'(MIN_HALF);
    localparam logic signed [N_BIT-1:0] MAX_V = N_BIT'(MAX_HALF);

    // Saturate the request to the accepted half-period window.
    always_comb begin
        // NOTE: assigning a default first means every path drives clamped, so no latch is inferred.
        clamped = half;
        if (half < MIN_V) begin
            clamped = MIN_V;
        end else if (half > MAX_V) begin
            clamped = MAX_V;
        end
    end

endmodule

// File: rtl/vco_gate_driver.sv
// Variable-frequency complementary gate generator. One period is
// DT_A -> ON_A -> DT_B -> ON_B, each half lasting half_q cycles, with the
// half-period latched only at period boundaries so frequency changes always
// apply to whole periods. All outputs are registered from the next state.
module vco_gate_driver
    import vco_gate_driver_pkg::*;
#(
    parameter int N_BIT     = DEF_N_BIT,
    parameter int DEAD_TIME = DEF_DEAD_TIME,
    parameter int MIN_HALF  = DEF_MIN_HALF,
    parameter int MAX_HALF  = DEF_MAX_HALF
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_EN,
    input  logic signed [N_BIT-1:0] i_HALF,
    output logic                    o_GATE_H,
    output logic                    o_GATE_L,
    output logic                    o_SYNC,
    output logic signed [N_BIT-1:0] o_HALF
);

    localparam int CNT_W = $clog2(MAX_HALF);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DT_LOAD = cnt_t'(DEAD_TIME - 1);

    state_t                  state, state_n;
    cnt_t                    cnt, cnt_n, on_load;
    logic signed [N_BIT-1:0] half_q, half_n, half_clamped;
    logic                    boundary;
    logic                    sync_n;
    logic                    gate_h_q, gate_l_q, sync_q;

    half_clamp #(
        .N_BIT    (N_BIT),
        .MIN_HALF (MIN_HALF),
        .MAX_HALF (MAX_HALF)
    ) u_half_clamp (
        .half    (i_HALF),
        .clamped (half_clamped)
    );

    // On-phase count reload; MIN_HALF > DEAD_TIME keeps this non-negative.
    assign on_load = cnt_t'(half_q - N_BIT'(DEAD_TIME + 1));

    // Next-state, counter and boundary latch; disable overrides everything.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        half_n   = half_q;
        sync_n   = 1'b0;
        boundary = 1'b0;
        if (!i_EN) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: boundary = 1'b1;
                DT_A: begin
                    if (cnt == '0) begin
                        state_n = ON_A;
                        cnt_n   = on_load;
                    end else begin
                        cnt_n = cnt - cnt_t'(1);
                    end
                end
                ON_A: begin
                    if (cnt == '0) begin
                        state_n = DT_B;
                        cnt_n   = DT_LOAD;
                    end else begin
                        cnt_n = cnt - cnt_t'(1);
                    end
                end
                DT_B: begin
                    if (cnt == '0) begin
                        state_n = ON_B;
                        cnt_n   = on_load;
                    end else begin
                        cnt_n = cnt - cnt_t'(1);
                    end
                end
                ON_B: begin
                    if (cnt == '0) begin
                        boundary = 1'b1;
                    end else begin
                        cnt_n = cnt - cnt_t'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
            if (boundary) begin
                state_n = DT_A;
                cnt_n   = DT_LOAD;
                half_n  = half_clamped;
                sync_n  = 1'b1;
            end
        end
    end

    // State, counter, latched half-period and registered output decode.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state    <= IDLE;
            cnt      <= '0;
            half_q   <= N_BIT'(MIN_HALF);
            gate_h_q <= 1'b0;
            gate_l_q <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_n;
            cnt      <= cnt_n;
            half_q   <= half_n;
            gate_h_q <= (state_n == ON_A);
            gate_l_q <= (state_n == ON_B);
            sync_q   <= sync_n;
        end
    end

    assign o_GATE_H = gate_h_q;
    assign o_GATE_L = gate_l_q;
    assign o_SYNC   = sync_q;
    assign o_HALF   = half_q;

endmodule
